// File: rtl/reflet_exti_gen.sv
// External-interrupt controller: maps nb_src peripheral requests onto 4 CPU lines via a byte-wide register window.
// Define REFLET_EXTI_GEN_SYNC_EN to add a two-flop synchroniser on every source (asynchronous sources allowed).
module reflet_exti_gen #(
    parameter int unsigned                base_addr_size = 16,
    parameter logic [base_addr_size-1:0]  base_addr      = 16'hFF04,
    parameter int unsigned                nb_src         = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic                      write_en,
    input  logic [7:0]                data_in,
    output logic [7:0]                data_out,
    output logic [3:0]                cpu_int,
    input  logic [nb_src-1:0]         src_int
);

    localparam int unsigned AW  = base_addr_size;
    localparam int unsigned AW1 = base_addr_size + 1;
    localparam int unsigned WIN = 4 + nb_src;

    logic [AW-1:0]           off;
    logic                    sel;
    logic                    wr;

    logic                    gen_q, gen_d;
    logic [nb_src-1:0]       en_q, en_d;
    logic [nb_src-1:0]       edge_q, edge_d;
    logic [nb_src-1:0][1:0]  line_q, line_d;
    logic [nb_src-1:0]       pend_q, pend_d;
    logic [nb_src-1:0]       p_q;
    logic [3:0]              cpu_int_q, cpu_int_d;

    logic [nb_src-1:0]       s;
    logic [nb_src-1:0]       set_c;
    logic [nb_src-1:0]       clr_c;
    logic [7:0]              top_c;
    logic [7:0]              rdata_c;

    // Window decode done one bit wider so base_addr + WIN cannot wrap.
    assign off = addr - base_addr;
    assign sel = enable
              && ({1'b0, addr} >= {1'b0, base_addr})
              && ({1'b0, addr} <  ({1'b0, base_addr} + AW1'(WIN)));
    assign wr  = sel && write_en;

`ifdef REFLET_EXTI_GEN_SYNC_EN
    logic [nb_src-1:0] meta_q;
    logic [nb_src-1:0] s_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            s_q    <= '0;
        end else begin
            meta_q <= src_int;
            s_q    <= meta_q;
        end
    end

    assign s = s_q;
`else
    assign s = src_int;
`endif

    // Pending set: rising edge of the sampled source, or the level itself.
    assign set_c = (s & ~p_q & edge_q) | (s & ~edge_q);

    always_comb begin
        gen_d  = gen_q;
        en_d   = en_q;
        edge_d = edge_q;
        line_d = line_q;
        clr_c  = '0;
        if (wr) begin
            if (off == AW'(0)) begin
                gen_d = data_in[0];
                if (data_in[1]) clr_c = '1;
            end
            if (off == AW'(3)) begin
                for (int unsigned i = 0; i < nb_src; i++) begin
                    if (32'(data_in) == i) clr_c[i] = 1'b1;
                end
            end
            for (int unsigned i = 0; i < nb_src; i++) begin
                if (off == AW'(4 + i)) begin
                    en_d[i]   = data_in[0];
                    line_d[i] = data_in[2:1];
                    edge_d[i] = data_in[3];
                    if (data_in[7]) clr_c[i] = 1'b1;
                end
            end
        end
        // A set arriving on the same edge as a clear wins.
        pend_d = set_c | (pend_q & ~clr_c);
    end

    always_comb begin
        cpu_int_d = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            for (int unsigned i = 0; i < nb_src; i++) begin
                if (pend_q[i] && en_q[i] && (line_q[i] == 2'(k))) cpu_int_d[k] = 1'b1;
            end
        end
        if (!gen_q) cpu_int_d = '0;
    end

    // Lowest-numbered pending and enabled source, 8'hFF when none.
    always_comb begin
        top_c = 8'hFF;
        for (int i = int'(nb_src) - 1; i >= 0; i--) begin
            if (pend_q[i] && en_q[i]) top_c = 8'(i);
        end
    end

    always_comb begin
        rdata_c = '0;
        if (sel) begin
            if (off == AW'(0)) rdata_c = {7'b0, gen_q};
            if (off == AW'(1)) rdata_c = 8'(nb_src);
            if (off == AW'(2)) rdata_c = top_c;
            for (int unsigned i = 0; i < nb_src; i++) begin
                if (off == AW'(4 + i)) rdata_c = {pend_q[i], 3'b000, edge_q[i], line_q[i], en_q[i]};
            end
        end
    end

    assign data_out = rdata_c;
    assign cpu_int  = cpu_int_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gen_q     <= 1'b0;
            en_q      <= '0;
            edge_q    <= '0;
            line_q    <= '0;
            pend_q    <= '0;
            p_q       <= '0;
            cpu_int_q <= '0;
        end else begin
            gen_q     <= gen_d;
            en_q      <= en_d;
            edge_q    <= edge_d;
            line_q    <= line_d;
            pend_q    <= pend_d;
            p_q       <= s;
            cpu_int_q <= cpu_int_d;
        end
    end

endmodule
